// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator.
//   pc_state_t    : control FSM states (BOOT, RUN, HALTED)
//   PC_STEP       : byte increment for sequential fetch
//   is_misaligned : alignment rule for a redirect target, from its low bits
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam int PC_STEP = 4;

    // Only the two low address bits matter to either alignment rule.
    // IALIGN=16 tolerates bit 1, IALIGN=32 needs both bits clear.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input int ialign);
        return (ialign == 16) ? addr_lo[0] : (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator at the head of the fetch stage.
// It presents a registered fetch address to instruction memory over a
// valid/ready handshake. Each cycle it takes one action, in priority order:
// trap vectoring, branch/jump redirect, halt, sequential advance. A redirect
// to a misaligned target is refused and reported. The block also counts
// accepted fetches.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   pc_ready        instruction memory accepts pc_out this cycle
//   redirect_i      branch/jump taken; target on redirect_pc_i
//   trap_i          trap/interrupt entry; vector base on trap_vec_i
//   halt_i, wake_i  enter / leave the halted state
//   pc_out          current fetch address (registered)
//   pc_valid        pc_out is a live fetch request
//   pc_misalign     one-cycle pulse for a refused misaligned redirect
//   bad_addr        last refused target
//   halted          block is in HALTED
//   fetch_count     accepted fetches, wraps modulo 2^CNT_W
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_ready,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_i,
    input  logic [XLEN-1:0]  trap_vec_i,
    input  logic             halt_i,
    input  logic             wake_i,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic             pc_misalign,
    output logic [XLEN-1:0]  bad_addr,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    pc_state_t        r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_valid;
    logic             r_misalign;
    logic [XLEN-1:0]  r_bad_addr;
    logic             r_halted;
    logic [CNT_W-1:0] r_count;

    pc_state_t        w_state_next;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_valid_next;
    logic             w_misalign_next;
    logic [XLEN-1:0]  w_bad_addr_next;
    logic             w_halted_next;
    logic [CNT_W-1:0] w_count_next;

    logic             w_accept;
    logic             w_redir_mis;
    logic [XLEN-1:0]  w_trap_pc;

    // pc_valid is only ever high in RUN, so this is an accepted fetch in RUN.
    assign w_accept    = r_valid && pc_ready;
    assign w_redir_mis = is_misaligned(redirect_pc_i[1:0], IALIGN);
    // Trap vectors are always word aligned, whatever IALIGN is.
    assign w_trap_pc   = trap_vec_i & ~XLEN'(PC_STEP - 1);

    // State register and registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_bad_addr <= '0;
            r_halted   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_valid    <= w_valid_next;
            r_misalign <= w_misalign_next;
            r_bad_addr <= w_bad_addr_next;
            r_halted   <= w_halted_next;
            r_count    <= w_count_next;
        end
    end

    // Next-state logic.
    // NOTE: each combinational block assigns a default to every output first,
    // so no path through the case/if tree can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            BOOT: w_state_next = RUN;
            RUN: begin
                // A trap or any redirect outranks halt, and RUN is kept.
                if (!trap_i && !redirect_i && halt_i)
                    w_state_next = HALTED;
            end
            HALTED: begin
                // A misaligned redirect is consumed and leaves the block halted.
                if (trap_i || (redirect_i && !w_redir_mis) || (!redirect_i && wake_i))
                    w_state_next = RUN;
            end
            default: w_state_next = BOOT;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_pc_next       = r_pc;
        w_bad_addr_next = r_bad_addr;
        w_misalign_next = 1'b0;
        // Accepted fetches are counted even when a trap, redirect or halt
        // overrides the advance in the same cycle.
        w_count_next    = w_accept ? r_count + CNT_W'(1) : r_count;
        w_valid_next    = (w_state_next == RUN);
        w_halted_next   = (w_state_next == HALTED);

        if (r_state != BOOT) begin
            if (trap_i) begin
                w_pc_next = w_trap_pc;
            end else if (redirect_i) begin
                if (w_redir_mis) begin
                    w_bad_addr_next = redirect_pc_i;
                    w_misalign_next = 1'b1;
                end else begin
                    w_pc_next = redirect_pc_i;
                end
            end else if ((r_state == RUN) && !halt_i && w_accept) begin
                w_pc_next = r_pc + XLEN'(PC_STEP);
            end
        end
    end

    assign pc_out      = r_pc;
    assign pc_valid    = r_valid;
    assign pc_misalign = r_misalign;
    assign bad_addr    = r_bad_addr;
    assign halted      = r_halted;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen. It drives two instances with identical
// stimulus:
//   A: IALIGN=32, CNT_W=32, RESET_VECTOR=0
//   B: IALIGN=16, CNT_W=3,  RESET_VECTOR=0x1000
// The driver steps a behavioural model for each instance and queues the
// expected outputs. A monitor pops each queue after every clock edge and
// compares the result against the instance.
module tb_pc_gen;

    typedef struct {
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          trap;
        logic [31:0] tvec;
        bit          halt;
        bit          wake;
    } stim_t;

    typedef struct {
        int          mode;    // 0: booting, 1: running, 2: halted
        logic [31:0] pc;
        bit          valid;
        bit          mis;
        logic [31:0] bad;
        bit          halted;
        longint      count;
    } mdl_t;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic [31:0] bad;
        logic        halted;
        logic [31:0] count;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        pc_ready;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] trap_vec_i;
    logic        halt_i;
    logic        wake_i;

    logic [31:0] pc_a, bad_a, cnt_a;
    logic        valid_a, mis_a, halted_a;
    logic [31:0] pc_b, bad_b;
    logic [2:0]  cnt_b;
    logic        valid_b, mis_b, halted_b;

    int n_tests = 0;
    int n_fail  = 0;

    mdl_t ma, mb;
    obs_t qa[$];
    obs_t qb[$];

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(32), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .pc_ready(pc_ready),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .halt_i(halt_i), .wake_i(wake_i),
        .pc_out(pc_a), .pc_valid(valid_a), .pc_misalign(mis_a),
        .bad_addr(bad_a), .halted(halted_a), .fetch_count(cnt_a)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .IALIGN(16), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .pc_ready(pc_ready),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .halt_i(halt_i), .wake_i(wake_i),
        .pc_out(pc_b), .pc_valid(valid_b), .pc_misalign(mis_b),
        .bad_addr(bad_b), .halted(halted_b), .fetch_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic mdl_t model_reset(input logic [31:0] rv);
        mdl_t m;
        m.mode = 0; m.pc = rv; m.valid = 0; m.mis = 0;
        m.bad = 0; m.halted = 0; m.count = 0;
        return m;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input int ialign);
        return (ialign == 32) ? (a % 4 != 0) : (a % 2 != 0);
    endfunction

    function automatic mdl_t step(input mdl_t m, input stim_t s, input int ialign, input int cnt_w);
        mdl_t   n = m;
        bit     accepted = m.valid && s.ready;
        longint pc_l;
        n.mis = 0;
        if (m.mode == 0) begin
            n.mode = 1; n.valid = 1;
        end else begin
            if (accepted) n.count = (m.count + 1) % (longint'(1) << cnt_w);
            if (s.trap) begin
                n.pc = s.tvec - (s.tvec % 4);
                n.mode = 1;
            end else if (s.redir && misaligned(s.rpc, ialign)) begin
                n.bad = s.rpc; n.mis = 1;
            end else if (s.redir) begin
                n.pc = s.rpc; n.mode = 1;
            end else if (m.mode == 1 && s.halt) begin
                n.mode = 2;
            end else if (m.mode == 2 && s.wake) begin
                n.mode = 1;
            end else if (m.mode == 1 && accepted) begin
                pc_l = longint'(m.pc) + 4;
                n.pc = 32'(pc_l % 64'h1_0000_0000);
            end
            n.valid  = (n.mode == 1);
            n.halted = (n.mode == 2);
        end
        return n;
    endfunction

    function automatic obs_t to_obs(input mdl_t m);
        obs_t o;
        o.pc = m.pc; o.valid = m.valid; o.mis = m.mis;
        o.bad = m.bad; o.halted = m.halted; o.count = 32'(m.count);
        return o;
    endfunction

    task automatic compare(input string tag, input obs_t act, input obs_t exp);
        check({tag, ".pc_out"},      64'(act.pc),     64'(exp.pc));
        check({tag, ".pc_valid"},    64'(act.valid),  64'(exp.valid));
        check({tag, ".pc_misalign"}, 64'(act.mis),    64'(exp.mis));
        check({tag, ".bad_addr"},    64'(act.bad),    64'(exp.bad));
        check({tag, ".halted"},      64'(act.halted), 64'(exp.halted));
        check({tag, ".fetch_count"}, 64'(act.count),  64'(exp.count));
    endtask

    function automatic obs_t sample_a();
        obs_t o;
        o.pc = pc_a; o.valid = valid_a; o.mis = mis_a;
        o.bad = bad_a; o.halted = halted_a; o.count = cnt_a;
        return o;
    endfunction

    function automatic obs_t sample_b();
        obs_t o;
        o.pc = pc_b; o.valid = valid_b; o.mis = mis_b;
        o.bad = bad_b; o.halted = halted_b; o.count = 32'(cnt_b);
        return o;
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        obs_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            compare("A", sample_a(), e);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            compare("B", sample_b(), e);
        end
    end

    // ---------------- driver ----------------
    function automatic stim_t idle(input bit ready);
        stim_t s;
        s.ready = ready; s.redir = 0; s.rpc = 0; s.trap = 0;
        s.tvec = 0; s.halt = 0; s.wake = 0;
        return s;
    endfunction

    // Apply one cycle of stimulus at the falling edge and queue the expected
    // outputs. Returns 2 time units after the rising edge.
    task automatic cycle(input stim_t s);
        @(negedge clk);
        pc_ready      = s.ready;
        redirect_i    = s.redir;
        redirect_pc_i = s.rpc;
        trap_i        = s.trap;
        trap_vec_i    = s.tvec;
        halt_i        = s.halt;
        wake_i        = s.wake;
        ma = step(ma, s, 32, 32);
        mb = step(mb, s, 16, 3);
        qa.push_back(to_obs(ma));
        qb.push_back(to_obs(mb));
        @(posedge clk);
        #2;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        stim_t s = idle(0);
        s.redir = 1; s.rpc = a;
        cycle(s);
    endtask

    // Hold reset for two edges and check the reset values. Release away
    // from any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        ma = model_reset(32'h0000_0000);
        mb = model_reset(32'h0000_1000);
        repeat (2) @(posedge clk);
        #2;
        check("rst.pc_a",     64'(pc_a),     64'h0);
        check("rst.pc_b",     64'(pc_b),     64'h1000);
        check("rst.valid_a",  64'(valid_a),  64'h0);
        check("rst.valid_b",  64'(valid_b),  64'h0);
        check("rst.mis_a",    64'(mis_a),    64'h0);
        check("rst.bad_a",    64'(bad_a),    64'h0);
        check("rst.halted_a", 64'(halted_a), 64'h0);
        check("rst.count_a",  64'(cnt_a),    64'h0);
        check("rst.count_b",  64'(cnt_b),    64'h0);
        #1 rst_n = 1'b1;
    endtask

    // Watchdog: the bench should never come near this.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        pc_ready = 0; redirect_i = 0; redirect_pc_i = 0;
        trap_i = 0; trap_vec_i = 0; halt_i = 0; wake_i = 0;

        do_reset();

        // Boot, then sequential fetch.
        cycle(idle(1));
        check("boot.pc_a",    64'(pc_a),    64'h0);
        check("boot.valid_a", 64'(valid_a), 64'h1);
        cycle(idle(1));
        cycle(idle(1));
        check("seq.pc_a", 64'(pc_a), 64'h8);

        // Stall with pc_ready low.
        repeat (3) cycle(idle(0));
        check("stall.pc_a",    64'(pc_a),  64'h8);
        check("stall.count_a", 64'(cnt_a), 64'h2);
        cycle(idle(1));
        check("resume.pc_a", 64'(pc_a), 64'hC);

        // Trap outranks a simultaneous redirect; vector low bits cleared.
        s = idle(0); s.trap = 1; s.tvec = 32'h103; s.redir = 1; s.rpc = 32'h200;
        cycle(s);
        check("trap_prio.pc_a", 64'(pc_a), 64'h100);

        // 0x202: misaligned for IALIGN=32, fine for IALIGN=16.
        redirect_to(32'h202);
        check("mis.flag_a", 64'(mis_a), 64'h1);
        check("mis.bad_a",  64'(bad_a), 64'h202);
        check("mis.pc_a",   64'(pc_a),  64'h100);
        check("ia16.pc_b",  64'(pc_b),  64'h202);
        cycle(idle(0));
        check("mis.pulse_end_a", 64'(mis_a), 64'h0);

        // Halt / wake / halt / trap.
        redirect_to(32'h40);
        s = idle(0); s.halt = 1; cycle(s);
        check("halt.halted_a", 64'(halted_a), 64'h1);
        check("halt.valid_a",  64'(valid_a),  64'h0);
        repeat (5) cycle(idle(1));
        s = idle(0); s.wake = 1; cycle(s);
        check("wake.pc_a",    64'(pc_a),    64'h40);
        check("wake.valid_a", 64'(valid_a), 64'h1);
        s = idle(1); s.halt = 1; cycle(s);     // halt with an accepted fetch
        s = idle(0); s.trap = 1; s.tvec = 32'h300; cycle(s);
        check("halt_trap.pc_a", 64'(pc_a), 64'h300);

        // Asynchronous reset mid-stream.
        redirect_to(32'h1C);
        cycle(idle(1));
        #1 rst_n = 1'b0;
        #1;
        check("async.pc_a",    64'(pc_a),    64'h0);
        check("async.valid_a", 64'(valid_a), 64'h0);
        check("async.count_a", 64'(cnt_a),   64'h0);
        do_reset();

        // Nine accepted fetches: CNT_W=3 wraps to 1.
        cycle(idle(1));
        repeat (9) cycle(idle(1));
        check("cnt.count_a", 64'(cnt_a), 64'd9);
        check("cnt.count_b", 64'(cnt_b), 64'd1);

        // PC wraps from the top of the address space.
        redirect_to(32'hFFFF_FFFC);
        cycle(idle(1));
        check("wrap.pc_a", 64'(pc_a), 64'h0);

        // Back-to-back misaligned redirects.
        redirect_to(32'h5);
        redirect_to(32'h7);
        check("b2b.mis_a", 64'(mis_a), 64'h1);
        check("b2b.bad_a", 64'(bad_a), 64'h7);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s = idle(($urandom % 4) != 0);
            s.trap  = ($urandom % 20) == 0;
            s.tvec  = $urandom;
            s.redir = ($urandom % 8) == 0;
            s.rpc   = $urandom;
            if ($urandom % 2) s.rpc[1:0] = 2'b00;
            s.halt  = ($urandom % 12) == 0;
            s.wake  = ($urandom % 4) == 0;
            cycle(s);
        end

        check("drain.qa", 64'(qa.size()), 64'h0);
        check("drain.qb", 64'(qb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
